// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder. It answers a master's cs/spi_clk with
// {LEAD_ZEROS zeros, sample} frames, MSB first.
// cs and spi_clk are synchronized into clk; nothing runs on spi_clk.
// Samples arrive through a one-entry holding buffer (valid/ready).
// Handshake: a sample transfers on any clk edge where sample_valid && sample_ready.
// sample_ready is simply "holding buffer empty".
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int LEAD_ZEROS  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              cs,
   input  logic              spi_clk,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              sdo,
   output logic              sdo_oe,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_abort,
   output logic              stale
);

   localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Bits [SYNC_STAGES-1:0] form the synchronizer. The top bit holds the
   // previous value of the last stage, so an edge is seen by comparing the two.
   logic [SYNC_STAGES:0]  cs_sync;
   logic [SYNC_STAGES:0]  sck_sync;
   logic                  cs_fall;
   logic                  cs_rise;
   logic                  sck_fall;

   state_t                state;
   state_t                state_d;
   logic [FRAME_BITS-1:0] shift;
   logic [FRAME_BITS-1:0] shift_d;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_d;
   logic                  hold_full;
   logic                  hold_full_d;
   logic [DATA_W-1:0]     hold;
   logic [DATA_W-1:0]     hold_d;
   logic [DATA_W-1:0]     last;
   logic [DATA_W-1:0]     last_d;
   logic [DATA_W-1:0]     word;
   logic                  accept;
   logic                  take;
   logic                  done_d;
   logic                  abort_d;
   logic                  stale_d;

   // Shift the asynchronous pins through the synchronizer.
   // It resets to 0, so a cs held low across reset is not taken as a new frame.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cs_sync  <= '0;
         sck_sync <= '0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-1:0], cs};
         sck_sync <= {sck_sync[SYNC_STAGES-1:0], spi_clk};
      end
   end

   assign cs_fall  =  cs_sync[SYNC_STAGES]  & ~cs_sync[SYNC_STAGES-1];
   assign cs_rise  = ~cs_sync[SYNC_STAGES]  &  cs_sync[SYNC_STAGES-1];
   assign sck_fall =  sck_sync[SYNC_STAGES] & ~sck_sync[SYNC_STAGES-1];

   assign accept       = sample_valid & ~hold_full;
   assign word         = hold_full ? hold : last;
   assign sample_ready = ~hold_full;
   assign sdo          = shift[FRAME_BITS-1];
   assign sdo_oe       = (state != IDLE);
   assign busy         = (state != IDLE);

   // Next-state logic for frame control, shifting and the holding buffer.
   // cs rising has priority over everything, so a simultaneous spi_clk fall is dropped.
   always_comb begin
      state_d     = state;
      shift_d     = shift;
      cnt_d       = cnt;
      hold_full_d = hold_full;
      hold_d      = hold;
      last_d      = last;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      stale_d     = 1'b0;
      take        = 1'b0;
      if (cs_rise) begin
         state_d = IDLE;
         shift_d = '0;
         cnt_d   = '0;
         abort_d = (state == SHIFT);
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state_d = SHIFT;
                  shift_d = FRAME_BITS'(word);
                  cnt_d   = CNT_W'(1);
                  if (hold_full) begin
                     take   = 1'b1;
                     last_d = hold;
                  end else begin
                     stale_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (sck_fall) begin
                  // After the last bit the register has shifted out to all
                  // zeros, which is what drives sdo low in DONE.
                  shift_d = {shift[FRAME_BITS-2:0], 1'b0};
                  if (cnt == CNT_W'(FRAME_BITS)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      // take needs a full buffer and accept needs an empty one, so both can never be set.
      if (take) begin
         hold_full_d = 1'b0;
      end else if (accept) begin
         hold_full_d = 1'b1;
         hold_d      = sample_in;
      end
   end

   // Register the FSM, the datapath and the event pulses.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state       <= IDLE;
         shift       <= '0;
         cnt         <= '0;
         hold_full   <= 1'b0;
         hold        <= '0;
         last        <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         stale       <= 1'b0;
      end else begin
         state       <= state_d;
         shift       <= shift_d;
         cnt         <= cnt_d;
         hold_full   <= hold_full_d;
         hold        <= hold_d;
         last        <= last_d;
         frame_done  <= done_d;
         frame_abort <= abort_d;
         stale       <= stale_d;
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder. A frame-level reference model follows the
// master pins as the responder sees them, after the synchronizer delay.
// Every clk cycle, all outputs are compared against that model.
// The words a master captures are also compared to hand-computed constants.
module tb_adc_spi_responder;
   localparam int DATA_W      = 12;
   localparam int LEAD_ZEROS  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int FRAME_BITS  = LEAD_ZEROS + DATA_W;

   logic              clk = 1'b0;
   logic              reset_b = 1'b0;
   logic              cs = 1'b1;
   logic              spi_clk = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              sample_ready;
   logic              sdo;
   logic              sdo_oe;
   logic              busy;
   logic              frame_done;
   logic              frame_abort;
   logic              stale;

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int n_abort = 0;
   int n_stale = 0;

   // clock
   always #5 clk = ~clk;

   adc_spi_responder #(
      .DATA_W(DATA_W), .LEAD_ZEROS(LEAD_ZEROS), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .reset_b(reset_b), .cs(cs), .spi_clk(spi_clk),
      .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sdo(sdo), .sdo_oe(sdo_oe), .busy(busy), .frame_done(frame_done),
      .frame_abort(frame_abort), .stale(stale)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pin history as the DUT perceives it: idx k holds the pin sampled k edges ago.
   logic cs_p  [0:SYNC_STAGES+1];
   logic sck_p [0:SYNC_STAGES+1];
   int                    m_state = 0;   // 0 idle, 1 sending, 2 finished
   int                    m_idx = 0;     // bit currently on sdo, 0 = MSB
   logic [FRAME_BITS-1:0] m_word = '0;
   logic                  m_full = 1'b0;
   logic [DATA_W-1:0]     m_hold = '0;
   logic [DATA_W-1:0]     m_last = '0;
   logic                  e_done = 1'b0;
   logic                  e_abort = 1'b0;
   logic                  e_stale = 1'b0;

   initial begin
      for (int k = 0; k <= SYNC_STAGES + 1; k++) begin
         cs_p[k]  = 1'b0;
         sck_p[k] = 1'b0;
      end
   end

   always @(posedge clk) begin
      logic c_new, c_old, k_new, k_old, acc, tk;
      if (!reset_b) begin
         for (int k = 0; k <= SYNC_STAGES + 1; k++) begin
            cs_p[k]  = 1'b0;
            sck_p[k] = 1'b0;
         end
         m_state = 0; m_idx = 0; m_word = '0; m_full = 1'b0; m_hold = '0; m_last = '0;
         e_done = 1'b0; e_abort = 1'b0; e_stale = 1'b0;
      end else begin
         for (int k = SYNC_STAGES + 1; k > 0; k--) begin
            cs_p[k]  = cs_p[k-1];
            sck_p[k] = sck_p[k-1];
         end
         cs_p[0]  = cs;
         sck_p[0] = spi_clk;
         c_new = cs_p[SYNC_STAGES];  c_old = cs_p[SYNC_STAGES+1];
         k_new = sck_p[SYNC_STAGES]; k_old = sck_p[SYNC_STAGES+1];
         e_done = 1'b0; e_abort = 1'b0; e_stale = 1'b0;
         tk  = 1'b0;
         acc = sample_valid && !m_full;
         if (!c_old && c_new) begin
            e_abort = (m_state == 1);
            m_state = 0;
            m_idx   = 0;
         end else if (m_state == 0 && c_old && !c_new) begin
            if (m_full) begin
               m_word = FRAME_BITS'(m_hold);
               m_last = m_hold;
               tk     = 1'b1;
            end else begin
               m_word  = FRAME_BITS'(m_last);
               e_stale = 1'b1;
            end
            m_state = 1;
            m_idx   = 0;
         end else if (m_state == 1 && k_old && !k_new) begin
            if (m_idx == FRAME_BITS - 1) begin
               m_state = 2;
               e_done  = 1'b1;
            end else begin
               m_idx++;
            end
         end
         if (tk) m_full = 1'b0;
         else if (acc) begin
            m_full = 1'b1;
            m_hold = sample_in;
         end
      end
   end

   // compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      logic x_sdo;
      if (!reset_b) begin
         check("rst_sdo", sdo, 0);
         check("rst_oe", sdo_oe, 0);
         check("rst_busy", busy, 0);
         check("rst_ready", sample_ready, 1);
         check("rst_pulses", {frame_done, frame_abort, stale}, 0);
      end else begin
         x_sdo = (m_state == 1) ? m_word[FRAME_BITS-1-m_idx] : 1'b0;
         check("sdo", sdo, x_sdo);
         check("sdo_oe", sdo_oe, m_state != 0);
         check("busy", busy, m_state != 0);
         check("sample_ready", sample_ready, !m_full);
         check("frame_done", frame_done, e_done);
         check("frame_abort", frame_abort, e_abort);
         check("stale", stale, e_stale);
         if (frame_done)  n_done++;
         if (frame_abort) n_abort++;
         if (stale)       n_stale++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] v);
      int n;
      n = 0;
      sample_in    = v;
      sample_valid = 1'b1;
      @(negedge clk);
      while (!sample_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_wait_bound", n < 200, 1);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic cs_drop(input int hp);
      cs = 1'b0;
      tick(hp);
   endtask

   task automatic clk_bits(input int n, input int hp, output logic [15:0] cap);
      cap = '0;
      for (int i = 0; i < n; i++) begin
         cap = {cap[14:0], sdo};
         spi_clk = 1'b1;
         tick(hp);
         spi_clk = 1'b0;
         tick(hp);
      end
   endtask

   task automatic cs_raise(input int hp);
      cs = 1'b1;
      tick(SYNC_STAGES + 1);
      check("oe_off_after_cs_rise", sdo_oe, 0);
      tick(hp);
   endtask

   task automatic full_frame(input int hp, output logic [15:0] cap);
      cs_drop(hp);
      clk_bits(FRAME_BITS, hp, cap);
      cs_raise(hp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] cap;
      int d0, s0, a0, hp, mode, k;

      // 1: reset with pins toggling
      for (int i = 0; i < 10; i++) begin
         tick(1);
         cs           = 1'($urandom_range(0, 1));
         spi_clk      = 1'($urandom_range(0, 1));
         sample_valid = 1'($urandom_range(0, 1));
         sample_in    = DATA_W'($urandom);
      end
      check("t1_sdo", sdo, 0);
      check("t1_oe", sdo_oe, 0);
      check("t1_ready", sample_ready, 1);
      cs = 1'b1; spi_clk = 1'b0; sample_valid = 1'b0;
      tick(1);
      reset_b = 1'b1;
      tick(6);

      // 2: one full frame
      push(12'hA5C);
      d0 = n_done;
      full_frame(8, cap);
      check("t2_word", cap, 16'h0A5C);
      check("t2_done_count", n_done - d0, 1);
      check("t2_ready", sample_ready, 1);

      // 3: resend without a new push
      s0 = n_stale;
      full_frame(8, cap);
      check("t3_word", cap, 16'h0A5C);
      check("t3_stale_count", n_stale - s0, 1);

      // 4: abort after 6 bits, then a fresh sample
      a0 = n_abort;
      cs_drop(8);
      clk_bits(6, 8, cap);
      cs_raise(8);
      check("t4_abort_count", n_abort - a0, 1);
      push(12'h123);
      s0 = n_stale;
      full_frame(8, cap);
      check("t4_word", cap, 16'h0123);
      check("t4_no_stale", n_stale - s0, 0);

      // 5: buffer full with another sample waiting
      push(12'h456);
      sample_in = 12'hFFF;
      sample_valid = 1'b1;
      tick(5);
      check("t5_ready_low", sample_ready, 0);
      full_frame(8, cap);
      check("t5_word_a", cap, 16'h0456);
      check("t5_refilled", sample_ready, 0);
      sample_valid = 1'b0;
      full_frame(8, cap);
      check("t5_word_b", cap, 16'h0FFF);

      // 6: reset mid-frame with cs held low
      push(12'h321);
      cs_drop(8);
      clk_bits(8, 8, cap);
      reset_b = 1'b0;
      #1;
      check("t6_oe", sdo_oe, 0);
      check("t6_busy", busy, 0);
      check("t6_sdo", sdo, 0);
      check("t6_ready", sample_ready, 1);
      tick(3);
      reset_b = 1'b1;
      tick(20);
      check("t6_no_frame", busy, 0);
      cs_raise(8);
      s0 = n_stale;
      full_frame(8, cap);
      check("t6_word", cap, 16'h0000);
      check("t6_stale", n_stale - s0, 1);

      // randomized frames, checked cycle by cycle by the model
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1 && sample_ready) push(DATA_W'($urandom));
         hp = $urandom_range(SYNC_STAGES + 2, 9);
         repeat ($urandom_range(0, 2)) begin
            spi_clk = 1'b1; tick(hp); spi_clk = 1'b0; tick(hp);
         end
         if ($urandom_range(0, 3) == 0) begin
            // sample offered in the very cycle the frame start is seen
            cs = 1'b0;
            tick(SYNC_STAGES);
            sample_in = DATA_W'($urandom);
            sample_valid = 1'b1;
            tick(hp - SYNC_STAGES);
         end else begin
            cs_drop(hp);
         end
         mode = $urandom_range(0, 3);
         k = $urandom_range(0, FRAME_BITS - 1);
         if (mode == 0) begin
            clk_bits(k, hp, cap);
            cs_raise(hp);
         end else if (mode == 1) begin
            clk_bits(k, hp, cap);
            spi_clk = 1'b1;
            tick(hp);
            spi_clk = 1'b0;
            cs = 1'b1;
            tick(SYNC_STAGES + 1);
            check("rnd_oe_off", sdo_oe, 0);
            tick(hp);
         end else begin
            clk_bits(FRAME_BITS, hp, cap);
            repeat ($urandom_range(0, 2)) begin
               spi_clk = 1'b1; tick(hp); spi_clk = 1'b0; tick(hp);
            end
            cs_raise(hp);
         end
         sample_valid = 1'b0;
         tick($urandom_range(1, 6));
      end

      tick(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // time bound
   initial begin
      #5000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
